// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between two masters.
// The winner's request is registered at grant and driven for RD_LAT+1 cycles, then acked.

module dmem_arb_port #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          hit,
  input  logic          rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          ack,
  output logic [DW-1:0] rdata
);
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= hit;
      if (hit && rd) rdata <= mem_rdata;
    end
  end
endmodule

module dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_wmem,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_wmem,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmem,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] LAT      = RD_LAT[1:0];

  logic [1:0]           state;
  logic [1:0]           cnt;
  logic                 sel, last, gp, fin;
  logic [3:0]           wmem_q;
  logic [1:0]           req;
  logic [1:0][AW-1:0]   addr_v;
  logic [1:0][DW-1:0]   wdata_v;
  logic [1:0][3:0]      wmem_v;
  logic [1:0]           ack_v;
  logic [1:0][DW-1:0]   rdata_v;

  assign req     = {m1_req, m0_req};
  assign addr_v  = {m1_addr, m0_addr};
  assign wdata_v = {m1_wdata, m0_wdata};
  assign wmem_v  = {m1_wmem, m0_wmem};

  // On a tie the port not served last wins; a lone requester always wins.
  always_comb begin
    gp = req[1];
    if (&req) gp = ~last;
  end

  assign fin  = (state == S_ACCESS) && (cnt == 2'd0);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      sel       <= 1'b0;
      last      <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wmem_q    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            sel       <= gp;
            last      <= gp;
            mem_addr  <= addr_v[gp];
            mem_wdata <= wdata_v[gp];
            wmem_q    <= wmem_v[gp];
            cnt       <= LAT;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else             state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe only in the first access cycle so each transaction writes exactly once.
  assign mem_wmem = (state == S_ACCESS && cnt == LAT) ? wmem_q : 4'd0;

  for (genvar i = 0; i < 2; i++) begin : g_port
    dmem_arb_port #(.DW(DW)) u_port (
      .clk       (clk),
      .clrn      (clrn),
      .hit       (fin && (int'(sel) == i)),
      .rd        (wmem_q == 4'd0),
      .mem_rdata (mem_rdata),
      .ack       (ack_v[i]),
      .rdata     (rdata_v[i])
    );
  end

  assign m0_ack   = ack_v[0];
  assign m1_ack   = ack_v[1];
  assign m0_rdata = rdata_v[0];
  assign m1_rdata = rdata_v[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: three builds (RD_LAT 1, 0, 3), each with its own memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int NI = 3;

  typedef struct {
    int          inst;
    int          port;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic mem_clr = 1'b1;
  logic [NI-1:0]        m0_req, m1_req, m0_ack, m1_ack, busy;
  logic [NI-1:0][31:0]  m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
  logic [NI-1:0][31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [NI-1:0][3:0]   m0_wmem, m1_wmem, mem_wmem;

  exp_t        sbq[$];
  logic [31:0] model [NI][64];
  int          strobes [NI];
  int          ack_seen [NI][2];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [31:0] mem [64];
    logic [31:0] pipe [3];
    logic [5:0]  idx;
    assign idx = mem_addr[g][7:2];

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(L)) u_dut (
      .clk(clk), .clrn(clrn),
      .m0_req(m0_req[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]), .m0_wmem(m0_wmem[g]),
      .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]), .m1_wmem(m1_wmem[g]),
      .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wmem(mem_wmem[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_wmem[g][b]) mem[idx][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
      pipe[0] <= mem[idx];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    if (L == 0) begin : g_comb
      assign mem_rdata[g] = mem[idx];
    end else begin : g_pipe
      assign mem_rdata[g] = pipe[L-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Ack monitor: every ack pops the scoreboard and checks port, instance and read data.
  always @(negedge clk) begin
    if (clrn) begin
      for (int g = 0; g < NI; g++) begin
        if (mem_wmem[g] != 4'd0) strobes[g]++;
        if (m0_ack[g] || m1_ack[g]) begin
          int   p;
          exp_t e;
          p = m1_ack[g] ? 1 : 0;
          chk("ack_excl", {63'd0, m0_ack[g] & m1_ack[g]}, 64'd0);
          ack_seen[g][p]++;
          if (sbq.size() == 0) begin
            chk("ack_unexpected", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("ack_inst", g, e.inst);
            chk("ack_port", p, e.port);
            if (e.rd) chk("rdata", (p == 1) ? m1_rdata[g] : m0_rdata[g], e.data);
          end
        end
      end
    end
  end

  task automatic drive(input int g, input int p, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    if (p == 0) begin
      m0_req[g] = r; m0_addr[g] = a; m0_wdata[g] = d; m0_wmem[g] = w;
    end else begin
      m1_req[g] = r; m1_addr[g] = a; m1_wdata[g] = d; m1_wmem[g] = w;
    end
  endtask

  task automatic push(input int g, input int p, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] w, output logic [31:0] exp_rd);
    exp_t e;
    e.inst = g; e.port = p; e.rd = (w == 4'd0); e.data = model[g][a[7:2]];
    for (int b = 0; b < 4; b++)
      if (w[b]) model[g][a[7:2]][8*b +: 8] = d[8*b +: 8];
    exp_rd = e.data;
    sbq.push_back(e);
  endtask

  task automatic wait_ack(input int g, input int p, output int n);
    logic a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      a = (p == 0) ? m0_ack[g] : m1_ack[g];
    end while (!a && n < 60);
    if (!a) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic txn(input int g, input int p, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] w);
    logic [31:0] er;
    int n;
    push(g, p, a, d, w, er);
    drive(g, p, 1'b1, a, d, w);
    wait_ack(g, p, n);
    chk("latency", n, lat_of(g) + 2);
    drive(g, p, 1'b0, a, d, w);
    @(negedge clk);
    if (w == 4'd0) chk("rdata_hold", (p == 1) ? m1_rdata[g] : m0_rdata[g], er);
  endtask

  initial begin
    int n, idle, acks, seen0;
    logic [31:0] er;
    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < 64; i++) model[g][i] = 32'd0;
      strobes[g] = 0; ack_seen[g][0] = 0; ack_seen[g][1] = 0;
      drive(g, 0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(g, 1, 1'b0, 32'd0, 32'd0, 4'd0);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_mem_addr", mem_addr[0], 0);
    chk("rst_mem_wdata", mem_wdata[0], 0);
    chk("rst_mem_wmem", mem_wmem[0], 0);
    chk("rst_acks", {m0_ack[0], m1_ack[0]}, 0);
    chk("rst_rdata", {m0_rdata[0], m1_rdata[0]}, 0);
    mem_clr = 1'b0;
    clrn = 1'b1;
    @(negedge clk);

    // Abort a write mid-access: nothing written, no ack afterwards
    drive(0, 0, 1'b1, 32'h20, 32'h12345678, 4'hF);
    @(negedge clk);
    chk("abort_busy", busy[0], 1);
    clrn = 1'b0;
    #1;
    chk("abort_busy_clr", busy[0], 0);
    chk("abort_wmem", mem_wmem[0], 0);
    chk("abort_addr", mem_addr[0], 0);
    chk("abort_wdata", mem_wdata[0], 0);
    drive(0, 0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (6) @(negedge clk);

    // Single write, then reads and a byte write
    strobes[0] = 0;
    txn(0, 0, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("wr_strobes", strobes[0], 1);
    chk("m1_quiet", ack_seen[0][1], 0);
    txn(0, 0, 32'h10, 32'd0, 4'h0);
    txn(0, 0, 32'h10, 32'h0000AA00, 4'b0010);
    txn(0, 0, 32'h10, 32'd0, 4'h0);
    chk("byte_merge", m0_rdata[0], 32'hDEADAAEF);
    txn(0, 0, 32'h20, 32'd0, 4'h0);
    chk("abort_no_write", m0_rdata[0], 32'd0);
    txn(0, 1, 32'h24, 32'h0BADF00D, 4'hF);

    // Both requesting from reset: m0,m1,m0,m1 with one idle cycle between
    @(negedge clk);
    clrn = 1'b0;
    drive(0, 0, 1'b1, 32'h10, 32'd0, 4'h0);
    drive(0, 1, 1'b1, 32'h24, 32'd0, 4'h0);
    for (int k = 0; k < 4; k++) push(0, k % 2, (k % 2) ? 32'h24 : 32'h10, 32'd0, 4'h0, er);
    @(negedge clk);
    clrn = 1'b1;
    idle = 0; acks = 0; n = 0;
    while (acks < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (!busy[0]) idle++;
      if (m0_ack[0] || m1_ack[0]) begin
        acks++;
        if (acks > 1) chk("idle_gap", idle, 1);
        idle = 0;
      end
    end
    chk("rr_acks", acks, 4);
    drive(0, 0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(0, 1, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);

    // m1 served alone, then a tie goes to m0; m0 drops req mid-access
    txn(0, 1, 32'h24, 32'd0, 4'h0);
    seen0 = ack_seen[0][0];
    push(0, 0, 32'h10, 32'd0, 4'h0, er);
    push(0, 1, 32'h30, 32'hCAFEF00D, 4'hF, er);
    drive(0, 0, 1'b1, 32'h10, 32'd0, 4'h0);
    drive(0, 1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    drive(0, 0, 1'b0, 32'h10, 32'd0, 4'h0);
    wait_ack(0, 0, n);
    chk("tie_m0_lat", n, 2);
    wait_ack(0, 1, n);
    chk("tie_m1_wait", n, 4);
    drive(0, 1, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("drop_one_ack", ack_seen[0][0] - seen0, 1);
    @(negedge clk);
    txn(0, 0, 32'h30, 32'd0, 4'h0);
    chk("m1_write_seen", m0_rdata[0], 32'hCAFEF00D);

    // RD_LAT=0 and RD_LAT=3 builds
    for (int g = 1; g < NI; g++) begin
      txn(g, 0, 32'h08, 32'hA5A55A5A ^ g, 4'hF);
      txn(g, 1, 32'h0C, 32'h13579BDF, 4'hF);
      txn(g, 0, 32'h0C, 32'd0, 4'h0);
      txn(g, 1, 32'h08, 32'd0, 4'h0);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end
endmodule
